// File: rtl/smmha_engine_pkg.sv
// Shared definitions for the smmha engine slice.
// Holds the default widths, the operation encodings, the engine FSM state
// enum and the controller<->engine struct types.
package smmha_engine_pkg;

  localparam int SMMHA_DATA_W = 32;
  localparam int SMMHA_CNT_W  = 16;
  localparam int SMMHA_OP_W   = 3;

  typedef enum logic [SMMHA_OP_W-1:0] {
    SMMHA_OP_ADD  = 3'd0,
    SMMHA_OP_SUB  = 3'd1,
    SMMHA_OP_MUL  = 3'd2,
    SMMHA_OP_AND  = 3'd3,
    SMMHA_OP_OR   = 3'd4,
    SMMHA_OP_XOR  = 3'd5,
    SMMHA_OP_MAX  = 3'd6,
    SMMHA_OP_PASS = 3'd7
  } smmha_op_e;

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_RUN  = 2'd1,
    ENG_DONE = 2'd2
  } eng_state_e;

  // Controller -> engine job configuration.
  typedef struct packed {
    logic                    clear;
    logic                    start;
    logic [SMMHA_CNT_W-1:0]  len;
    logic [SMMHA_DATA_W-1:0] operand;
    logic [SMMHA_OP_W-1:0]   operation;
  } ctrl_engine_t;

  // Engine -> controller status.
  typedef struct packed {
    logic [SMMHA_CNT_W-1:0] cnt;
    logic                   busy;
    logic                   done;
  } flags_engine_t;

endpackage

// File: rtl/smmha_engine_if.sv
// Word stream interface used for the engine's A input and D output streams.
// Handshake: a word transfers on a rising clock edge where valid & ready are
// both high. Once valid is raised by the master, data and valid stay stable
// until that transfer happens; ready may change freely.
//   data  : stream word
//   valid : master has a word
//   ready : slave can take a word
interface smmha_engine_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/smmha_alu.sv
// Purely combinational element-wise operation: o_result = op(i_a, i_operand),
// truncated to DATA_W with two's complement wrap.
//   i_op      : operation selector (smmha_op_e encoding)
//   i_a       : stream word
//   i_operand : scalar operand
//   o_result  : result word
module smmha_alu
  import smmha_engine_pkg::*;
#(
  parameter int DATA_W = SMMHA_DATA_W,
  parameter int OP_W   = SMMHA_OP_W
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_operand,
  output logic [DATA_W-1:0] o_result
);

  logic [DATA_W-1:0] w_prod;

  // Same-width product keeps only the low DATA_W bits.
  assign w_prod = i_a * i_operand;

  always_comb begin
    o_result = i_a;
    case (i_op)
      SMMHA_OP_ADD:  o_result = i_a + i_operand;
      SMMHA_OP_SUB:  o_result = i_a - i_operand;
      SMMHA_OP_MUL:  o_result = w_prod;
      SMMHA_OP_AND:  o_result = i_a & i_operand;
      SMMHA_OP_OR:   o_result = i_a | i_operand;
      SMMHA_OP_XOR:  o_result = i_a ^ i_operand;
      SMMHA_OP_MAX:  o_result = ($signed(i_a) > $signed(i_operand)) ? i_a : i_operand;
      SMMHA_OP_PASS: o_result = i_a;
      default:       o_result = i_a;
    endcase
  end

endmodule

// File: rtl/smmha_engine.sv
// smmha datapath engine: consumes ctrl_len_i words from stream A, applies one
// element-wise operation per word and emits each result on stream D one cycle
// later through a single output register.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   clear_i              : global synchronous clear
//   ctrl_clear_i         : controller clear (high while controller idle)
//   ctrl_start_i         : one-cycle job start
//   ctrl_len_i           : words in the job
//   ctrl_operand_i       : scalar operand
//   ctrl_operation_i     : operation selector
//   a                    : input stream (slave)
//   d                    : output stream (master)
//   cnt_o                : outputs delivered in the current job
//   busy_o               : job running
//   done_o               : pulse with the final output transfer
//   dbg_state_o          : FSM state for observation
module smmha_engine
  import smmha_engine_pkg::*;
#(
  parameter int DATA_W = SMMHA_DATA_W,
  parameter int CNT_W  = SMMHA_CNT_W,
  parameter int OP_W   = SMMHA_OP_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              ctrl_clear_i,
  input  logic              ctrl_start_i,
  input  logic [CNT_W-1:0]  ctrl_len_i,
  input  logic [DATA_W-1:0] ctrl_operand_i,
  input  logic [OP_W-1:0]   ctrl_operation_i,
  smmha_engine_if.slave     a,
  smmha_engine_if.master    d,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output eng_state_e        dbg_state_o
);

  eng_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_len, r_in_cnt, r_cnt;
  logic [DATA_W-1:0] r_operand, r_data;
  logic [OP_W-1:0]   r_op;
  logic              r_valid;

  logic              w_clr, w_run, w_start, w_a_ready;
  logic              w_in_hs, w_out_hs, w_last_out;
  logic [DATA_W-1:0] w_result;

  assign w_clr   = clear_i | ctrl_clear_i;
  assign w_run   = (r_state == ENG_RUN);
  // A start while running is ignored; from IDLE or DONE it begins a new job.
  assign w_start = ctrl_start_i & ~w_run;

  // Accept a word only while words remain and the output register is free
  // or being emptied in the same cycle.
  assign w_a_ready  = w_run & (r_in_cnt < r_len) & (~r_valid | d.ready);
  assign w_in_hs    = a.valid & w_a_ready;
  assign w_out_hs   = r_valid & d.ready;
  assign w_last_out = w_run & w_out_hs & ((r_cnt + CNT_W'(1)) == r_len);

  smmha_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .i_op      (r_op),
    .i_a       (a.data),
    .i_operand (r_operand),
    .o_result  (w_result)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ENG_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ENG_IDLE, ENG_DONE: begin
        if (ctrl_start_i) w_state_nxt = (ctrl_len_i == '0) ? ENG_DONE : ENG_RUN;
      end
      ENG_RUN: begin
        if (w_last_out) w_state_nxt = ENG_DONE;
      end
      default: w_state_nxt = ENG_IDLE;
    endcase
    // Clear wins over start and over job completion.
    if (w_clr) w_state_nxt = ENG_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len     <= '0;
      r_operand <= '0;
      r_op      <= '0;
      r_in_cnt  <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else if (w_clr) begin
      r_len     <= '0;
      r_operand <= '0;
      r_op      <= '0;
      r_in_cnt  <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else begin
      // Outside RUN no transfers happen, so start never competes with them.
      if (w_start) begin
        r_len     <= ctrl_len_i;
        r_operand <= ctrl_operand_i;
        r_op      <= ctrl_operation_i;
        r_in_cnt  <= '0;
        r_cnt     <= '0;
      end
      if (w_in_hs) begin
        r_data   <= w_result;
        r_in_cnt <= r_in_cnt + CNT_W'(1);
      end
      if (w_in_hs)       r_valid <= 1'b1;
      else if (w_out_hs) r_valid <= 1'b0;
      if (w_out_hs) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign a.ready     = w_a_ready;
  assign d.data      = r_data;
  assign d.valid     = r_valid;
  assign cnt_o       = r_cnt;
  assign busy_o      = w_run;
  assign done_o      = w_last_out;
  assign dbg_state_o = r_state;

endmodule
